// File: rtl/ci_stim_fpga_wrapper.sv
// Biphasic stimulus sequencer: steers an H-bridge and current source through
// cathodic / gap / anodic / rest phases, clocked from the on-chip oscillator.
`timescale 1ns/1ps
module ci_stim_fpga_wrapper #(
  parameter int PHASE_UNIT = 33,
  parameter int IDLE_UNIT  = 3333,
  parameter int GAP_CYC    = 33
) (
  input  logic       i_rst_n,
  input  logic       i_start_btn,
  input  logic       i_stop_btn,
  input  logic [2:0] i_duty,
  input  logic [2:0] i_idle,
  output logic       o_ano_top,
  output logic       o_ano_bot,
  output logic       o_cat_top,
  output logic       o_cat_bot,
  output logic       o_curr_ena,
  output logic       o_led_r,
  output logic       o_led_g,
  output logic       o_led_b
);

  // state | meaning: STOPPED outputs off, wait start | CATH cathodic phase | GAP interphase
  // gap | ANOD anodic phase | REST inter-pulse idle | IDLE_WAIT never entered, recovers to STOPPED
  typedef enum logic [2:0] {IDLE_WAIT, CATH, GAP, ANOD, REST, STOPPED} state_t;

  localparam int CW = 16;
  // switch vector packing: {ano_top, ano_bot, cat_top, cat_bot, curr_ena}
  localparam logic [4:0] SW_OFF  = 5'b00000;
  localparam logic [4:0] SW_CATH = 5'b01101;
  localparam logic [4:0] SW_ANOD = 5'b10011;

  // Oscillator clock net, driven by the on-chip oscillator.
  logic w_force_clk;
  assign w_force_clk = 1'b0;

  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  logic [1:0] r_start_sync;
  logic [1:0] r_stop_sync;
  logic       w_stop_in;
  logic       w_start;
  logic       w_stop;

  state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_duty;
  logic [2:0] r_idle;
  logic [4:0] r_sw;
  logic       r_led_r;
  logic       r_led_g;
  logic       r_led_b;

  function automatic logic [CW-1:0] phase_len(input logic [2:0] code);
    return CW'((32'(code) + 32'd1) * 32'(PHASE_UNIT) - 32'd1);
  endfunction

  function automatic logic [CW-1:0] idle_len(input logic [2:0] code);
    return CW'((32'(code) + 32'd1) * 32'(IDLE_UNIT) - 32'd1);
  endfunction

  always_ff @(posedge w_force_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // A floating stop pad reads as inactive.
  assign w_stop_in = (i_stop_btn === 1'b1);

  always_ff @(posedge w_force_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_start_sync <= 2'b00;
      r_stop_sync  <= 2'b00;
    end else begin
      r_start_sync <= {r_start_sync[0], i_start_btn};
      r_stop_sync  <= {r_stop_sync[0], w_stop_in};
    end
  end
  assign w_start = r_start_sync[1];
  assign w_stop  = r_stop_sync[1];

  always_ff @(posedge w_force_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= STOPPED;
      r_cnt   <= '0;
      r_duty  <= '0;
      r_idle  <= '0;
      r_sw    <= SW_OFF;
      r_led_r <= 1'b0;
      r_led_g <= 1'b1;
      r_led_b <= 1'b1;
    end else if (w_stop) begin
      r_state <= STOPPED;
      r_cnt   <= '0;
      r_sw    <= SW_OFF;
      r_led_r <= 1'b0;
      r_led_g <= 1'b1;
    end else begin
      case (r_state)
        STOPPED: begin
          if (w_start) begin
            r_state <= CATH;
            r_cnt   <= phase_len(i_duty);
            r_duty  <= i_duty;
            r_idle  <= i_idle;
            r_sw    <= SW_CATH;
            r_led_r <= 1'b1;
            r_led_g <= 1'b0;
            r_led_b <= ~r_led_b;
          end
        end
        CATH: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= GAP;
            r_cnt   <= CW'(GAP_CYC - 1);
            r_sw    <= SW_OFF;
          end
        end
        GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= ANOD;
            r_cnt   <= phase_len(r_duty);
            r_sw    <= SW_ANOD;
          end
        end
        ANOD: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= REST;
            r_cnt   <= idle_len(r_idle);
            r_sw    <= SW_OFF;
          end
        end
        REST: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_start) begin
            r_state <= CATH;
            r_cnt   <= phase_len(i_duty);
            r_duty  <= i_duty;
            r_idle  <= i_idle;
            r_sw    <= SW_CATH;
            r_led_b <= ~r_led_b;
          end else begin
            r_state <= STOPPED;
            r_led_r <= 1'b0;
            r_led_g <= 1'b1;
          end
        end
        default: begin
          r_state <= STOPPED;
          r_cnt   <= '0;
          r_sw    <= SW_OFF;
          r_led_r <= 1'b0;
          r_led_g <= 1'b1;
        end
      endcase
    end
  end

  assign o_ano_top  = r_sw[4];
  assign o_ano_bot  = r_sw[3];
  assign o_cat_top  = r_sw[2];
  assign o_cat_bot  = r_sw[1];
  assign o_curr_ena = r_sw[0];
  assign o_led_r    = r_led_r;
  assign o_led_g    = r_led_g;
  assign o_led_b    = r_led_b;

endmodule

// File: tb/tb_ci_stim_fpga_wrapper.sv
// Bench for ci_stim_fpga_wrapper: elapsed-time reference model compared every
// cycle, plus directed phase-length, stop, code-change and reset checks.
`timescale 1ns/1ps
module tb_ci_stim_fpga_wrapper;

  localparam int PU  = 33;
  localparam int IU  = 3333;
  localparam int GAP = 33;
  localparam logic [4:0] P_OFF  = 5'b00000;
  localparam logic [4:0] P_CATH = 5'b01101;
  localparam logic [4:0] P_ANOD = 5'b10011;

  logic       r_clk;
  logic       i_rst_n, i_start_btn, i_stop_btn;
  logic [2:0] i_duty, i_idle;
  logic       o_ano_top, o_ano_bot, o_cat_top, o_cat_bot, o_curr_ena;
  logic       o_led_r, o_led_g, o_led_b;

  int n_checks = 0;
  int n_pass   = 0;
  int n_curr   = 0;

  ci_stim_fpga_wrapper dut (
    .i_rst_n(i_rst_n), .i_start_btn(i_start_btn), .i_stop_btn(i_stop_btn),
    .i_duty(i_duty), .i_idle(i_idle),
    .o_ano_top(o_ano_top), .o_ano_bot(o_ano_bot),
    .o_cat_top(o_cat_top), .o_cat_bot(o_cat_bot),
    .o_curr_ena(o_curr_ena),
    .o_led_r(o_led_r), .o_led_g(o_led_g), .o_led_b(o_led_b)
  );

  initial begin
    r_clk = 1'b0;
    #25;
    forever begin
      r_clk = 1'b1; #150;
      r_clk = 1'b0; #150;
    end
  end

  initial force dut.w_force_clk = r_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual 'h%0h required 'h%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [4:0] sw();
    return {o_ano_top, o_ano_bot, o_cat_top, o_cat_bot, o_curr_ena};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {sw(), o_led_r, o_led_g, o_led_b};
  endfunction

  // Reference model: pulse train described by time elapsed since the CATH entry.
  bit m_rs0, m_rs1, m_q1s, m_q2s, m_q1p, m_q2p, m_run, m_ledb, m_ss, m_sp, m_core_rst;
  int m_t, m_d, m_i;

  function automatic int cyc_len(input int d, input int i);
    return 2 * (d + 1) * PU + GAP + (i + 1) * IU;
  endfunction

  function automatic logic [7:0] model_out();
    int c;
    logic [4:0] s;
    c = (m_d + 1) * PU;
    s = P_OFF;
    if (m_run) begin
      if (m_t < c)                s = P_CATH;
      else if (m_t < c + GAP)     s = P_OFF;
      else if (m_t < 2 * c + GAP) s = P_ANOD;
    end
    return {s, m_run, !m_run, m_ledb};
  endfunction

  always @(posedge r_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_rs0 = 0; m_rs1 = 0; m_q1s = 0; m_q2s = 0; m_q1p = 0; m_q2p = 0;
      m_run = 0; m_ledb = 1; m_t = 0;
    end else begin
      m_core_rst = !m_rs1;
      m_rs1 = m_rs0;
      m_rs0 = 1;
      if (m_core_rst) begin
        m_q1s = 0; m_q2s = 0; m_q1p = 0; m_q2p = 0; m_run = 0; m_ledb = 1;
      end else begin
        m_ss = m_q2s; m_sp = m_q2p;
        m_q2s = m_q1s; m_q1s = i_start_btn;
        m_q2p = m_q1p; m_q1p = (i_stop_btn === 1'b1);
        if (m_sp) begin
          m_run = 0;
        end else if (!m_run) begin
          if (m_ss) begin
            m_run = 1; m_t = 0; m_d = int'(i_duty); m_i = int'(i_idle); m_ledb = !m_ledb;
          end
        end else begin
          m_t++;
          if (m_t == cyc_len(m_d, m_i)) begin
            if (m_ss) begin
              m_t = 0; m_d = int'(i_duty); m_i = int'(i_idle); m_ledb = !m_ledb;
            end else begin
              m_run = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    @(posedge r_clk);
    forever begin
      @(negedge r_clk);
      chk("outputs_vs_model", dut_vec(), model_out());
      chk("break_before_make",
          int'((o_ano_top & o_cat_bot & o_cat_top & o_ano_bot) |
               (o_ano_top & o_cat_top) | (o_ano_bot & o_cat_bot)), 0);
    end
  end

  always @(posedge r_clk) begin
    #50;
    if (o_curr_ena) n_curr++;
  end

  task automatic wait_pat(input logic [4:0] pat, input int limit, input string name,
                          output int k);
    k = 0;
    while (sw() != pat && k < limit) begin
      @(negedge r_clk);
      k++;
    end
    chk(name, sw(), pat);
  endtask

  task automatic run_len(input logic [4:0] pat, input int limit, output int n);
    n = 0;
    while (sw() == pat && n < limit) begin
      n++;
      @(negedge r_clk);
    end
  endtask

  initial begin
    int n, k, c0;
    i_rst_n = 1'b0; i_start_btn = 1'b0; i_stop_btn = 1'b0;
    i_duty = 3'd7; i_idle = 3'd7;
    #100 i_rst_n = 1'b1;
    repeat (3) @(negedge r_clk);
    chk("reset_outputs", dut_vec(), 8'b00000_011);
    #225 i_start_btn = 1'b1;

    wait_pat(P_CATH, 10, "start_to_cath", k);
    chk("ledb_first_toggle", o_led_b, 0);
    c0 = n_curr;
    run_len(P_CATH, 300, n);   chk("d7_cath_len", n, 264);
    run_len(P_OFF, 300, n);    chk("d7_gap_len", n, 33);
    run_len(P_ANOD, 300, n);   chk("d7_anod_len", n, 264);
    i_duty = 3'd0; i_idle = 3'd0;
    run_len(P_OFF, 30000, n);  chk("i7_rest_len", n, 26664);
    chk("curr_per_period", n_curr - c0, 528);
    chk("cycle2_entry", sw(), P_CATH);
    chk("ledb_second_toggle", o_led_b, 1);

    run_len(P_CATH, 300, n);   chk("d0_cath_len", n, 33);
    run_len(P_OFF, 300, n);    chk("d0_gap_len", n, 33);
    run_len(P_ANOD, 300, n);   chk("d0_anod_len", n, 33);
    i_duty = 3'd7;
    run_len(P_OFF, 5000, n);   chk("i0_rest_len", n, 3333);

    i_duty = 3'd0;
    run_len(P_CATH, 300, n);   chk("midcycle_cath_len", n, 264);
    run_len(P_OFF, 300, n);    chk("midcycle_gap_len", n, 33);
    run_len(P_ANOD, 300, n);   chk("midcycle_anod_len", n, 264);
    run_len(P_OFF, 5000, n);   chk("midcycle_rest_len", n, 3333);
    run_len(P_CATH, 300, n);   chk("next_cath_len", n, 33);
    run_len(P_OFF, 300, n);    chk("next_gap_len", n, 33);
    chk("anod_reached", sw(), P_ANOD);

    repeat (5) @(negedge r_clk);
    i_stop_btn = 1'b1;
    k = 0;
    while (sw() != P_OFF && k < 10) begin
      @(negedge r_clk);
      k++;
    end
    chk("stop_latency", k, 3);
    chk("stop_led_r", o_led_r, 0);
    repeat (10) @(negedge r_clk);
    chk("stopped_hold", dut_vec(), {P_OFF, 3'b01, o_led_b});
    i_stop_btn = 1'b0;
    wait_pat(P_CATH, 10, "restart_cath", k);
    chk("restart_latency", k, 3);
    run_len(P_CATH, 300, n);   chk("restart_cath_len", n, 33);
    run_len(P_OFF, 300, n);    chk("restart_gap_len", n, 33);
    repeat (4) @(negedge r_clk);
    chk("anod_before_reset", sw(), P_ANOD);

    #10 i_rst_n = 1'b0;
    #1 chk("async_reset_outputs", dut_vec(), 8'b00000_011);
    #100 i_rst_n = 1'b1;
    i_start_btn = 1'b0;
    repeat (200) @(negedge r_clk);
    chk("final_stopped", dut_vec(), 8'b00000_011);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ci_stim_fpga_wrapper.md
CI_STIM_FPGA_WRAPPER -- requirements
Module: ci_stim_fpga_wrapper

Interface
REQ-001 Parameters: PHASE_UNIT, 33, clocks per duty step (~10 us at 300 ns clock); IDLE_UNIT, 3333, clocks per idle step (~1 ms); GAP_CYC, 33, clocks of interphase gap.
REQ-002 w_force_clk  internal  1  sole clock, rising-edge; has no port, is driven by the on-chip oscillator (nominal 300 ns period), and SHALL remain a named internal net so a bench can force it.
REQ-003 i_rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_start_btn  in  1  active-high start request (level).
REQ-005 i_stop_btn  in  1  active-high stop request; pulled down internally; X/Z SHALL be treated as inactive.
REQ-006 i_duty  in  3  phase-width code, 0..7.
REQ-007 i_idle  in  3  inter-pulse idle code, 0..7.
REQ-008 o_ano_top, o_ano_bot, o_cat_top, o_cat_bot  out  1 each  H-bridge switch enables, active-high.
REQ-009 o_curr_ena  out  1  current-source enable, active-high.
REQ-010 o_led_r, o_led_g, o_led_b  out  1 each  status LEDs, active-low.

Function
REQ-011 i_start_btn and i_stop_btn SHALL each pass through a 2-flop synchronizer before use.
REQ-012 FSM states: IDLE_WAIT, CATH, GAP, ANOD, REST, STOPPED.
REQ-013 STOPPED: all switch outputs and o_curr_ena low; go to CATH on the cycle after synchronized start=1 and stop=0.
REQ-014 On entry to CATH, i_duty and i_idle SHALL be latched; these values hold for the whole pulse cycle.
REQ-015 CATH lasts (duty+1)*PHASE_UNIT clocks: o_cat_top=1, o_ano_bot=1, o_curr_ena=1, others 0.
REQ-016 GAP lasts GAP_CYC clocks: all switches 0, o_curr_ena=0.
REQ-017 ANOD lasts (duty+1)*PHASE_UNIT clocks: o_ano_top=1, o_cat_bot=1, o_curr_ena=1, others 0.
REQ-018 REST lasts (idle+1)*IDLE_UNIT clocks with all outputs 0, then: start still 1 -> CATH (new latch); start 0 -> STOPPED.
REQ-019 Break-before-make: o_ano_top&o_cat_bot and o_cat_top&o_ano_bot SHALL never be simultaneously high; o_ano_top&o_cat_top and o_ano_bot&o_cat_bot SHALL never be high.
REQ-020 Synchronized stop=1 in any state SHALL force STOPPED on the next clock with all switches/o_curr_ena 0; stop has priority over start when both are asserted.
REQ-021 Duration counter SHALL be at least 15 bits wide, with terminal count on value-1 (no off-by-one; exact durations per REQ-015..018).
REQ-022 Code changes on i_duty/i_idle mid-cycle SHALL NOT affect the current cycle.
REQ-023 LEDs: STOPPED -> o_led_r=0 (on), others 1; CATH/GAP/ANOD/REST -> o_led_g=0; o_led_b SHALL toggle at each CATH entry.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 While i_rst_n=0: state=STOPPED, counters 0, switch outputs and o_curr_ena 0, o_led_r=0, o_led_g=1, o_led_b=1, synchronizers 0.
REQ-026 Release of i_rst_n SHALL be synchronized to w_force_clk (async assert, sync deassert).
REQ-027 Reset asserted mid-pulse SHALL drop all switch outputs immediately (asynchronously).

Verification
REQ-028 Reset 100 ns, start=0 -> all switches 0, o_led_r=0, o_curr_ena=0 indefinitely.
REQ-029 Start=1 at 1000 ns, duty=7, idle=7, stop unconnected -> CATH 264 clocks, GAP 33, ANOD 264, REST 26664, repeating; o_curr_ena high 528 clocks per period.
REQ-030 duty=0, idle=0 -> CATH 33, GAP 33, ANOD 33, REST 3333 clocks.
REQ-031 Stop=1 during ANOD -> all switch outputs 0 within 3 clocks (sync + 1), o_led_r=0; restarts in CATH after stop=0 with start=1.
REQ-032 Change duty 7->0 during CATH -> current cycle stays 264/264 clocks; next cycle 33/33.
REQ-033 Every clock over a 3 s run -> break-before-make checks of REQ-019 never violated; o_led_b toggles once per pulse.
